// File: rtl/id_stage_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_fwd
//  Purpose  : Registered MIPS decode stage with multi-source operand
//             forwarding, load-use stall detection and ID/EX stall/flush.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NFWD   = 2,
    parameter int AOP_W  = 8,
    parameter int ASEL_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_valid_i,
    input  logic [31:0]              inst_i,
    input  logic [DATA_W-1:0]        reg1_data_i,
    input  logic [DATA_W-1:0]        reg2_data_i,
    input  logic [NFWD-1:0]          fwd_wreg_i,
    input  logic [NFWD*REG_AW-1:0]   fwd_wd_i,
    input  logic [NFWD*DATA_W-1:0]   fwd_wdata_i,
    input  logic                     ex_load_i,
    input  logic [REG_AW-1:0]        ex_wd_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    output logic                     reg1_read_o,
    output logic                     reg2_read_o,
    output logic [REG_AW-1:0]        reg1_addr_o,
    output logic [REG_AW-1:0]        reg2_addr_o,
    output logic                     stall_req_o,
    output logic                     valid_o,
    output logic [AOP_W-1:0]         aluop_o,
    output logic [ASEL_W-1:0]        alusel_o,
    output logic [DATA_W-1:0]        reg1_o,
    output logic [DATA_W-1:0]        reg2_o,
    output logic [REG_AW-1:0]        wd_o,
    output logic                     wreg_o
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_XORI    = 6'h0E;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;

    localparam logic [AOP_W-1:0]  c_AOP_AND  = AOP_W'(8'h24);
    localparam logic [AOP_W-1:0]  c_AOP_OR   = AOP_W'(8'h25);
    localparam logic [AOP_W-1:0]  c_AOP_XOR  = AOP_W'(8'h26);
    localparam logic [AOP_W-1:0]  c_AOP_SLL  = AOP_W'(8'h7C);
    localparam logic [AOP_W-1:0]  c_AOP_LW   = AOP_W'(8'hE3);
    localparam logic [ASEL_W-1:0] c_SEL_LOGIC = ASEL_W'(3'd1);
    localparam logic [ASEL_W-1:0] c_SEL_SHIFT = ASEL_W'(3'd2);
    localparam logic [ASEL_W-1:0] c_SEL_LOAD  = ASEL_W'(3'd7);

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_op    = inst_i[31:26];
    assign w_rs    = inst_i[25:21];
    assign w_rt    = inst_i[20:16];
    assign w_rd    = inst_i[15:11];
    assign w_shamt = inst_i[10:6];
    assign w_funct = inst_i[5:0];
    assign w_imm   = inst_i[15:0];

    logic              w_rd1_en;
    logic              w_rd2_en;
    logic [AOP_W-1:0]  w_aluop;
    logic [ASEL_W-1:0] w_alusel;
    logic [REG_AW-1:0] w_wd;
    logic              w_wreg;
    logic [DATA_W-1:0] w_k1;
    logic [DATA_W-1:0] w_k2;

    always_comb begin
        w_rd1_en = 1'b0;
        w_rd2_en = 1'b0;
        w_aluop  = '0;
        w_alusel = '0;
        w_wd     = '0;
        w_wreg   = 1'b0;
        w_k1     = '0;
        w_k2     = '0;
        case (w_op)
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_rd1_en = 1'b1;
                w_k2     = DATA_W'(w_imm);
                w_wd     = REG_AW'(w_rt);
                w_wreg   = 1'b1;
                w_alusel = c_SEL_LOGIC;
                w_aluop  = (w_op == c_OP_ANDI) ? c_AOP_AND :
                           (w_op == c_OP_ORI)  ? c_AOP_OR  : c_AOP_XOR;
            end
            c_OP_LUI: begin
                w_k2     = DATA_W'({w_imm, 16'h0000});
                w_wd     = REG_AW'(w_rt);
                w_wreg   = 1'b1;
                w_alusel = c_SEL_LOGIC;
                w_aluop  = c_AOP_OR;
            end
            c_OP_LW: begin
                w_rd1_en = 1'b1;
                w_k2     = DATA_W'($signed(w_imm));
                w_wd     = REG_AW'(w_rt);
                w_wreg   = 1'b1;
                w_alusel = c_SEL_LOAD;
                w_aluop  = c_AOP_LW;
            end
            c_OP_SPECIAL: begin
                // Register-register logic ops reuse funct directly as aluop
                if (w_shamt == 5'd0 && w_funct[5:2] == 4'b1001) begin
                    w_rd1_en = 1'b1;
                    w_rd2_en = 1'b1;
                    w_wd     = REG_AW'(w_rd);
                    w_wreg   = 1'b1;
                    w_alusel = c_SEL_LOGIC;
                    w_aluop  = AOP_W'(w_funct);
                end else if (w_rs == 5'd0 && (w_funct == 6'h00 || w_funct == 6'h02 ||
                                              w_funct == 6'h03)) begin
                    w_rd2_en = 1'b1;
                    w_k1     = DATA_W'(w_shamt);
                    w_wd     = REG_AW'(w_rd);
                    w_wreg   = 1'b1;
                    w_alusel = c_SEL_SHIFT;
                    w_aluop  = (w_funct == 6'h00) ? c_AOP_SLL : AOP_W'(w_funct);
                end
            end
            default: ;
        endcase
    end

    assign reg1_read_o = w_rd1_en;
    assign reg2_read_o = w_rd2_en;
    assign reg1_addr_o = REG_AW'(w_rs);
    assign reg2_addr_o = REG_AW'(w_rt);

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Scan oldest to youngest so the lowest-index match is the one that sticks
    always_comb begin
        w_op1 = reg1_data_i;
        w_op2 = reg2_data_i;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && fwd_wd_i[k*REG_AW +: REG_AW] == reg1_addr_o)
                w_op1 = fwd_wdata_i[k*DATA_W +: DATA_W];
            if (fwd_wreg_i[k] && fwd_wd_i[k*REG_AW +: REG_AW] == reg2_addr_o)
                w_op2 = fwd_wdata_i[k*DATA_W +: DATA_W];
        end
        if (!w_rd1_en)
            w_op1 = w_k1;
        else if (reg1_addr_o == '0)
            w_op1 = '0;
        if (!w_rd2_en)
            w_op2 = w_k2;
        else if (reg2_addr_o == '0)
            w_op2 = '0;
    end

    assign stall_req_o = inst_valid_i && ex_load_i && (ex_wd_i != '0) &&
                         ((w_rd1_en && reg1_addr_o == ex_wd_i) ||
                          (w_rd2_en && reg2_addr_o == ex_wd_i));

    always_ff @(posedge clk) begin
        if (rst || flush_i || (!stall_i && stall_req_o)) begin
            valid_o  <= 1'b0;
            aluop_o  <= '0;
            alusel_o <= '0;
            reg1_o   <= '0;
            reg2_o   <= '0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
        end else if (!stall_i) begin
            valid_o  <= inst_valid_i;
            aluop_o  <= w_aluop;
            alusel_o <= w_alusel;
            reg1_o   <= w_op1;
            reg2_o   <= w_op2;
            wd_o     <= w_wd;
            wreg_o   <= w_wreg && inst_valid_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage_fwd
//  Purpose  : Scoreboard bench for id_stage_fwd against an instruction-level
//             reference model, directed cases followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_fwd;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] r1d, r2d;
    logic [1:0]  fwd_wreg;
    logic [9:0]  fwd_wd;
    logic [63:0] fwd_wdata;
    logic        ex_load;
    logic [4:0]  ex_wd;
    logic        stall, flush;
    logic        reg1_read, reg2_read, stall_req;
    logic [4:0]  reg1_addr, reg2_addr;
    logic        valid_o, wreg_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wd_o;

    id_stage_fwd dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .inst_i(inst),
        .reg1_data_i(r1d), .reg2_data_i(r2d),
        .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
        .ex_load_i(ex_load), .ex_wd_i(ex_wd), .stall_i(stall), .flush_i(flush),
        .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
        .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
        .stall_req_o(stall_req), .valid_o(valid_o), .aluop_o(aluop_o),
        .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
    } idex_t;

    typedef struct {
        bit        r1en, r2en;
        bit [7:0]  aluop;
        bit [2:0]  alusel;
        bit [4:0]  wd;
        bit        wreg;
        bit [31:0] k1, k2;
    } dec_t;

    idex_t sb[$];
    idex_t cur;
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    running  = 0;

    function automatic idex_t bubble();
        idex_t b;
        b = '0;
        return b;
    endfunction

    // Instruction-set reference: what each MIPS encoding means
    function automatic dec_t ref_decode(bit [31:0] w);
        dec_t d;
        bit [5:0] op = w[31:26];
        bit [5:0] fn = w[5:0];
        d = '{default: '0};
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            d.r1en = 1; d.k2 = {16'h0, w[15:0]}; d.wd = w[20:16]; d.wreg = 1; d.alusel = 1;
            d.aluop = (op == 6'h0C) ? 8'h24 : (op == 6'h0D) ? 8'h25 : 8'h26;
        end else if (op == 6'h0F) begin
            d.k2 = {w[15:0], 16'h0}; d.wd = w[20:16]; d.wreg = 1; d.alusel = 1; d.aluop = 8'h25;
        end else if (op == 6'h23) begin
            d.r1en = 1; d.k2 = {{16{w[15]}}, w[15:0]}; d.wd = w[20:16]; d.wreg = 1;
            d.alusel = 7; d.aluop = 8'hE3;
        end else if (op == 6'h00 && w[10:6] == 0 && fn >= 6'h24 && fn <= 6'h27) begin
            d.r1en = 1; d.r2en = 1; d.wd = w[15:11]; d.wreg = 1; d.alusel = 1; d.aluop = {2'b0, fn};
        end else if (op == 6'h00 && w[25:21] == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
            d.r2en = 1; d.k1 = {27'h0, w[10:6]}; d.wd = w[15:11]; d.wreg = 1; d.alusel = 2;
            d.aluop = (fn == 0) ? 8'h7C : {2'b0, fn};
        end
        return d;
    endfunction

    function automatic bit [31:0] operand(bit en, bit [4:0] a, bit [31:0] k, bit [31:0] rf);
        if (!en) return k;
        if (a == 0) return 32'h0;
        for (int i = 0; i < 2; i++)
            if (fwd_wreg[i] && fwd_wd[i*5 +: 5] == a) return fwd_wdata[i*32 +: 32];
        return rf;
    endfunction

    function automatic bit [31:0] itype(bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit [31:0] rtype(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit [4:0] sh, bit [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    // Applied at negedge: check combinational outputs, predict the next ID/EX
    task automatic cycle();
        dec_t  d;
        bit    sreq;
        idex_t nxt;
        #1;
        d = ref_decode(inst);
        sreq = inst_valid && ex_load && ex_wd != 0 &&
               ((d.r1en && inst[25:21] == ex_wd) || (d.r2en && inst[20:16] == ex_wd));
        n_checks++;
        if ({reg1_read, reg2_read, reg1_addr, reg2_addr, stall_req} ===
            {d.r1en, d.r2en, inst[25:21], inst[20:16], sreq})
            n_pass++;
        else
            $display("FAIL comb inst=%h got rd=%b%b a1=%0d a2=%0d sreq=%b expected rd=%b%b a1=%0d a2=%0d sreq=%b",
                     inst, reg1_read, reg2_read, reg1_addr, reg2_addr, stall_req,
                     d.r1en, d.r2en, inst[25:21], inst[20:16], sreq);
        if (rst || flush)      nxt = bubble();
        else if (stall)        nxt = cur;
        else if (sreq)         nxt = bubble();
        else begin
            nxt.valid  = inst_valid;
            nxt.aluop  = d.aluop;
            nxt.alusel = d.alusel;
            nxt.r1     = operand(d.r1en, inst[25:21], d.k1, r1d);
            nxt.r2     = operand(d.r2en, inst[20:16], d.k2, r2d);
            nxt.wd     = d.wd;
            nxt.wreg   = d.wreg && inst_valid;
        end
        cur = nxt;
        sb.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; flush = 0; stall = 0; ex_load = 0; ex_wd = 0;
        fwd_wreg = 0; fwd_wd = 0; fwd_wdata = 0; inst_valid = 1;
    endtask

    initial begin : monitor
        idex_t exp_v, act;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                act = {valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o};
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL idex scoreboard empty, got %h", act);
                end else begin
                    exp_v = sb.pop_front();
                    if (act === exp_v) n_pass++;
                    else $display("FAIL idex got v=%b op=%h sel=%0d r1=%h r2=%h wd=%0d we=%b expected v=%b op=%h sel=%0d r1=%h r2=%h wd=%0d we=%b",
                                  act.valid, act.aluop, act.alusel, act.r1, act.r2, act.wd, act.wreg,
                                  exp_v.valid, exp_v.aluop, exp_v.alusel, exp_v.r1, exp_v.r2, exp_v.wd, exp_v.wreg);
                end
            end
        end
    end

    initial begin : driver
        quiet();
        rst = 1; inst = 0; r1d = 0; r2d = 0;
        cur = bubble();
        @(negedge clk);
        running = 1;
        repeat (3) cycle();
        rst = 0;
        // ORI $2,$1,0x1234
        inst = itype(6'h0D, 1, 2, 16'h1234); r1d = 32'hF0; cycle();
        // OR $3,$1,$1 with two matching forwarders, then only the older one
        inst = rtype(1, 1, 3, 0, 6'h25); r1d = 32'h1111; r2d = 32'h2222;
        fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h5555, 32'hAAAA_0000};
        cycle();
        fwd_wreg = 2'b10; cycle();
        // ANDI $4,$0,0xFFFF with a forwarder targeting $0
        inst = itype(6'h0C, 0, 4, 16'hFFFF); fwd_wreg = 2'b01; fwd_wd = 10'd0;
        fwd_wdata = {32'h0, 32'hDEAD}; r1d = 32'h7777; cycle();
        quiet();
        // Load-use: OR $6,$5,$7 behind a load to $5
        inst = rtype(5, 7, 6, 0, 6'h25); r1d = 32'h55; r2d = 32'h77;
        ex_load = 1; ex_wd = 5; cycle();
        ex_load = 0; cycle();
        // LUI $8,0xBEEF then hold, then flush during stall
        inst = itype(6'h0F, 0, 8, 16'hBEEF); cycle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin inst = $urandom; r1d = $urandom; cycle(); end
        flush = 1; cycle();
        quiet();
        // Invalid opcode, then reset in the middle of a stall
        inst = 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF); cycle();
        inst = itype(6'h0D, 3, 9, 16'h00FF); cycle();
        stall = 1; rst = 1; cycle();
        quiet();
        // Random traffic over a small register window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            int  kind;
            bit [4:0] a, b, c;
            a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
            kind = $urandom_range(0, 8);
            case (kind)
                0: inst = itype(6'h0D, a, b, 16'($urandom));
                1: inst = itype(6'h0C, a, b, 16'($urandom));
                2: inst = itype(6'h0E, a, b, 16'($urandom));
                3: inst = itype(6'h0F, a, b, 16'($urandom));
                4: inst = itype(6'h23, a, b, 16'($urandom));
                5: inst = rtype(a, b, c, ($urandom_range(0, 5) == 0) ? 5'd3 : 5'd0,
                                6'(6'h24 + $urandom_range(0, 3)));
                6: inst = rtype(($urandom_range(0, 5) == 0) ? a : 5'd0, b, c, 5'($urandom),
                                ($urandom_range(0, 2) == 0) ? 6'h00 : ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03);
                default: inst = $urandom;
            endcase
            inst_valid = ($urandom_range(0, 9) != 0);
            r1d = $urandom; r2d = $urandom;
            fwd_wreg = 2'($urandom);
            fwd_wd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_wdata = {$urandom, $urandom};
            ex_load = ($urandom_range(0, 3) == 0);
            ex_wd = 5'($urandom_range(0, 7));
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        running = 0;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
